// File: rtl/ibex_xif_dummy_reseed_ctrl.sv
// Reseed scheduler for the dummy-instruction generator: periodic entropy fetch plus CSR seed merge.
// Define IBEX_XIF_DUMMY_RESEED_TIMEOUT_EN to build the request timeout and sticky failure flag.
module ibex_xif_dummy_reseed_ctrl #(
  parameter int unsigned ReseedPeriod   = 256,
  parameter int unsigned EntropyTimeout = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dummy_instr_en_i,
  input  logic        insert_dummy_instr_i,
  input  logic        id_in_ready_i,
  input  logic        csr_seed_en_i,
  input  logic [31:0] csr_seed_i,
  output logic        edn_req_o,
  input  logic        edn_ack_i,
  input  logic [31:0] edn_data_i,
  output logic        dummy_instr_seed_en_o,
  output logic [31:0] dummy_instr_seed_o,
  output logic        reseed_busy_o,
  output logic        reseed_fail_o
);

  localparam int unsigned CntW = $clog2(ReseedPeriod);
  localparam logic [CntW-1:0] CntLast = CntW'(ReseedPeriod - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    APPLY
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]       r_hold;
  logic              r_ent_pend;
  logic              r_seed_en;
  logic [31:0]       r_seed;
  logic              w_accept, w_count, w_wrap, w_ack_ok, w_ent_fire, w_timeout;

  assign w_accept   = insert_dummy_instr_i & id_in_ready_i;
  assign w_count    = (r_state == IDLE) & dummy_instr_en_i & w_accept;
  assign w_wrap     = w_count & (r_cnt == CntLast) & ~csr_seed_en_i;
  assign w_ack_ok   = (r_state == REQ) & edn_ack_i & dummy_instr_en_i;
  // A CSR write in the ack cycle takes the output slot; the entropy seed
  // is then issued from the holding register one cycle later while APPLY holds.
  assign w_ent_fire = ~csr_seed_en_i & (w_ack_ok | ((r_state == APPLY) & r_ent_pend));

`ifdef IBEX_XIF_DUMMY_RESEED_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(EntropyTimeout);
  localparam logic [ToW-1:0] ToLast = ToW'(EntropyTimeout - 1);

  logic [ToW-1:0] r_to;
  logic           r_fail;

  assign w_timeout = (r_state == REQ) & ~edn_ack_i & (r_to == ToLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to   <= '0;
      r_fail <= 1'b0;
    end else begin
      if ((r_state == REQ) && !edn_ack_i) r_to <= r_to + ToW'(1);
      else                                r_to <= '0;
      if (w_timeout)                          r_fail <= 1'b1;
      else if (w_ent_fire || csr_seed_en_i)   r_fail <= 1'b0;
    end
  end

  assign reseed_fail_o = r_fail;
`else
  assign w_timeout     = 1'b0;
  assign reseed_fail_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_wrap) w_state_nxt = REQ;
      REQ: begin
        if (edn_ack_i)      w_state_nxt = dummy_instr_en_i ? APPLY : IDLE;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      APPLY: if (!r_ent_pend) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (csr_seed_en_i)  w_cnt_nxt = '0;
    else if (w_count)   w_cnt_nxt = (r_cnt == CntLast) ? '0 : r_cnt + CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_ent_pend <= 1'b0;
      r_seed_en  <= 1'b0;
      r_seed     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ent_pend <= csr_seed_en_i & (w_ack_ok | ((r_state == APPLY) & r_ent_pend));
      if (w_ack_ok) r_hold <= edn_data_i;
      if (csr_seed_en_i) begin
        r_seed_en <= 1'b1;
        r_seed    <= csr_seed_i;
      end else if (w_ent_fire) begin
        r_seed_en <= 1'b1;
        r_seed    <= w_ack_ok ? edn_data_i : r_hold;
      end else begin
        r_seed_en <= 1'b0;
      end
    end
  end

  assign edn_req_o             = (r_state == REQ);
  assign reseed_busy_o         = (r_state != IDLE);
  assign dummy_instr_seed_en_o = r_seed_en;
  assign dummy_instr_seed_o    = r_seed;

endmodule
